// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART frame parser and the matching TX frame builder.
// State encoding and default frame start byte.
package uart_frame_parser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_parser.sv
// Frame delineator: HEADER, LEN, LEN payload bytes, CHK (sum of LEN and payload).
// Optional inter-byte timeout is built when FRAME_TIMEOUT_EN is defined.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 500_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic [7:0] frame_len,
    output logic       frame_done,
    output logic       frame_err
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYC < 2) begin : g_cfg_check
        $error("uart_frame_parser: illegal parameter values");
    end

    state_t     state;
    logic [7:0] len;
    logic [7:0] cnt;
    logic [7:0] csum;
    logic       tmo_hit;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC);

    logic [TW-1:0] tmo_cnt;

    // A byte arriving on the expiry cycle wins over the timeout.
    assign tmo_hit = (state != ST_IDLE) && !pi_flag &&
                     (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || pi_flag || tmo_hit || state == ST_IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            len        <= 8'd0;
            cnt        <= 8'd0;
            csum       <= 8'd0;
            po_data    <= 8'd0;
            po_flag    <= 1'b0;
            frame_len  <= 8'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            po_flag    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (tmo_hit) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end else if (pi_flag) begin
                unique case (state)
                    ST_IDLE: begin
                        if (pi_data == HEADER) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        len  <= pi_data;
                        csum <= pi_data;
                        cnt  <= 8'd0;
                        if (pi_data == 8'd0 || pi_data > MAX_LEN_B) begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        po_data <= pi_data;
                        po_flag <= 1'b1;
                        csum    <= csum + pi_data;
                        cnt     <= cnt + 8'd1;
                        if (cnt == len - 8'd1) begin
                            state <= ST_CHK;
                        end
                    end
                    ST_CHK: begin
                        if (pi_data == csum) begin
                            frame_done <= 1'b1;
                            frame_len  <= len;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser against a positional frame model.
// Exercises the FRAME_TIMEOUT_EN build when that macro is defined.
module tb_uart_frame_parser;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic [7:0] po_data;
    logic       po_flag;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       frame_err;

    uart_frame_parser #(.TIMEOUT_CYC(100)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .pi_data    (pi_data),
        .pi_flag    (pi_flag),
        .po_data    (po_data),
        .po_flag    (po_flag),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  tx[$];
    logic [18:0] obs_q[$];
    logic [18:0] exp_q[$];
    int          gap_hits;
    int          last_cyc;

    // Model: position within the current frame, -1 while hunting for HEADER.
    int         m_pos = -1;
    int         m_len = 0;
    int         m_sum = 0;
    logic [7:0] m_pd = 8'd0;
    logic [7:0] m_flen = 8'd0;

    function automatic void model_reset();
        m_pos  = -1;
        m_pd   = 8'd0;
        m_flen = 8'd0;
    endfunction

    function automatic logic [18:0] model_step(input logic [7:0] b);
        logic pf = 1'b0;
        logic dn = 1'b0;
        logic er = 1'b0;
        if (m_pos < 0) begin
            if (b == 8'hA5) m_pos = 0;
        end else if (m_pos == 0) begin
            m_len = int'(b);
            m_sum = int'(b);
            if (m_len == 0 || m_len > 16) begin
                er = 1'b1;
                m_pos = -1;
            end else begin
                m_pos = 1;
            end
        end else if (m_pos <= m_len) begin
            pf    = 1'b1;
            m_pd  = b;
            m_sum = (m_sum + int'(b)) % 256;
            m_pos = m_pos + 1;
        end else begin
            if (int'(b) == m_sum) begin
                dn     = 1'b1;
                m_flen = 8'(m_len);
            end else begin
                er = 1'b1;
            end
            m_pos = -1;
        end
        return {pf, m_pd, dn, er, m_flen};
    endfunction

    function automatic logic [18:0] outs();
        return {po_flag, po_data, frame_done, frame_err, frame_len};
    endfunction

    task automatic run(input bit b2b);
        obs_q.delete();
        exp_q.delete();
        gap_hits = 0;
        foreach (tx[i]) begin
            @(negedge sys_clk);
            pi_flag = 1'b1;
            pi_data = tx[i];
            exp_q.push_back(model_step(tx[i]));
            @(posedge sys_clk);
            #1;
            last_cyc = cyc;
            obs_q.push_back(outs());
            if (!b2b) begin
                @(negedge sys_clk);
                pi_flag = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge sys_clk);
                    #1;
                    if (po_flag || frame_done || frame_err) gap_hits++;
                end
            end
        end
        @(negedge sys_clk);
        pi_flag = 1'b0;
        @(posedge sys_clk);
        #1;
        if (po_flag || frame_done || frame_err) gap_hits++;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        pi_flag   = 1'b0;
        pi_data   = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        n_cmp++;
        if (outs() !== 19'd0) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", outs(), 19'd0);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_good_frame();
        tx = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run(1'b0);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL good[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (gap_hits !== 0) begin
            n_bad++;
            $display("FAIL good_gap: got %0d pulses want 0", gap_hits);
        end
    endtask

    task automatic test_bad_checksum();
        tx = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
        run(1'b0);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL badchk[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (frame_len !== 8'h03) begin
            n_bad++;
            $display("FAIL badchk_len: got %h want 03", frame_len);
        end
    endtask

    task automatic test_illegal_len();
        tx = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7F, 8'h80};
        run(1'b0);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL illegal[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (gap_hits !== 0) begin
            n_bad++;
            $display("FAIL illegal_gap: got %0d pulses want 0", gap_hits);
        end
    endtask

    task automatic test_header_as_data();
        tx = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'hA5, 8'hA6};
        run(1'b0);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL hdrdata[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        tx = '{8'hA5, 8'h04, 8'h10, 8'h20};
        run(1'b0);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL midrst[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) begin
            @(posedge sys_clk);
            #1;
            n_cmp++;
            if (outs() !== 19'd0) begin
                n_bad++;
                $display("FAIL midrst_out: got %h want %h", outs(), 19'd0);
            end
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        tx = '{8'hA5, 8'h01, 8'h05, 8'h06};
        run(1'b1);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int len;
        int sum;
        repeat (40) begin
            tx.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                tx.push_back(b);
            end
            tx.push_back(8'hA5);
            len = $urandom_range(0, 20);
            tx.push_back(8'(len));
            if (len >= 1 && len <= 16) begin
                sum = len;
                repeat (len) begin
                    b = 8'($urandom);
                    sum += int'(b);
                    tx.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) sum += 1 + $urandom_range(0, 254);
                tx.push_back(8'(sum));
            end
            run(1'($urandom_range(0, 1)));
            foreach (tx[i]) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if (gap_hits !== 0) begin
                n_bad++;
                $display("FAIL rand_gap: got %0d pulses want 0", gap_hits);
            end
        end
    endtask

    task automatic test_timeout();
        int d = 0;
        int hits = 0;
        bit got = 0;
        tx = '{8'hA5, 8'h02, 8'hAA};
        run(1'b1);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL tmo_pre[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
`ifdef FRAME_TIMEOUT_EN
        while (d < 200 && !got) begin
            @(posedge sys_clk);
            #1;
            d = cyc - last_cyc;
            if (frame_err) got = 1;
            else if (po_flag || frame_done) hits++;
        end
        n_cmp++;
        if (!got || d != 100 || hits != 0) begin
            n_bad++;
            $display("FAIL timeout: got err=%0d at %0d cycles want err=1 at 100", got, d);
        end
        m_pos = -1;
        tx = '{8'hA5, 8'h01, 8'h05, 8'h06};
`else
        repeat (10_000) begin
            @(posedge sys_clk);
            #1;
            if (po_flag || frame_done || frame_err) hits++;
        end
        n_cmp++;
        if (hits != 0) begin
            n_bad++;
            $display("FAIL no_timeout: got %0d pulses want 0", hits);
        end
        tx = '{8'hBB, 8'h67};
`endif
        run(1'b1);
        foreach (tx[i]) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL tmo_post[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_illegal_len();
        test_header_as_data();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
